// File: rtl/mem_arb.sv
// Round-robin arbiter that shares the DDR controller command port among PORTS burst clients.
// Optional MEMARB_PRIO0_EN: port 0 wins every arbitration it takes part in; the other ports rotate among themselves.
module mem_arb #(
    parameter int PORTS = 2,
    parameter int AW    = 23,
    parameter int DW    = 32,
    parameter int LW    = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [PORTS-1:0]    preq,
    input  logic [PORTS-1:0]    pwr,
    input  logic [AW*PORTS-1:0] paddr,
    input  logic [LW*PORTS-1:0] plen,
    input  logic [DW*PORTS-1:0] pwdata,
    output logic [PORTS-1:0]    pack,
    output logic [PORTS-1:0]    pready,
    output logic                mreq,
    output logic                mwr,
    output logic [AW-1:0]       maddr,
    output logic [LW-1:0]       mlen,
    output logic [DW-1:0]       mwdata,
    input  logic                mack,
    input  logic                mready,
    output logic [2:0]          owner,
    output logic                busy
);

    localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [OW-1:0] own_q, own_nx;
    logic [OW-1:0] rr_q, rr_nx;
    logic [LW-1:0] cnt_q, cnt_nx;
    logic [OW-1:0] sel_idx;
    logic [OW-1:0] cand;
    logic          sel_valid;

    logic [AW-1:0] addr_a  [PORTS];
    logic [LW-1:0] len_a   [PORTS];
    logic [DW-1:0] wdata_a [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign addr_a[i]  = paddr[AW*i +: AW];
        assign len_a[i]   = plen[LW*i +: LW];
        assign wdata_a[i] = pwdata[DW*i +: DW];
    end

    // Scan from the port after the pointer; descending k lets the nearest requester win.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = OW'((int'(rr_q) + k) % PORTS);
            if (preq[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef MEMARB_PRIO0_EN
        if (preq[0]) begin
            sel_valid = 1'b1;
            sel_idx   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            own_q <= '0;
            rr_q  <= OW'(PORTS - 1);
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            own_q <= own_nx;
            rr_q  <= rr_nx;
            cnt_q <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        own_nx   = own_q;
        rr_nx    = rr_q;
        cnt_nx   = cnt_q;
        mreq     = 1'b0;
        pack     = '0;
        pready   = '0;
        case (state)
            S_IDLE: begin
                if (sel_valid) begin
                    own_nx   = sel_idx;
                    cnt_nx   = len_a[sel_idx];
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                mreq = 1'b1;
                if (mack) begin
                    pack[own_q] = 1'b1;
                    state_nx    = S_DATA;
                end
            end
            S_DATA: begin
                if (mready) begin
                    pready[own_q] = 1'b1;
                    if (cnt_q == '0) begin
                        state_nx = S_IDLE;
`ifdef MEMARB_PRIO0_EN
                        // Port 0 grants must not disturb the rotation among the others.
                        if (own_q != '0) rr_nx = own_q;
`else
                        rr_nx = own_q;
`endif
                    end else begin
                        cnt_nx = cnt_q - 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mwr    = pwr[own_q];
    assign maddr  = addr_a[own_q];
    assign mlen   = len_a[own_q];
    assign mwdata = wdata_a[own_q];
    assign owner  = 3'(own_q);
    assign busy   = (state != S_IDLE);

endmodule
